// File: rtl/text_uart_tx.sv
// Character FIFO feeding an async serialiser: start bit, 7 data bits LSB first,
// optional even parity, then 1 or 2 stop bits. The line idles high.
module text_uart_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 8,
  parameter int PARITY_EN    = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  char_in,
  input  logic        char_valid,
  output logic        char_ready,
  output logic        tx_bit,
  output logic        tx_busy,
  output logic        frame_done,
  output logic [15:0] frame_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CYC_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [1:0]    STOP_LAST = 2'(STOP_BITS - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [6:0]    mem_q [FIFO_DEPTH];
  logic [6:0]    mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;

  state_t        state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [2:0]    bit_q, bit_d;
  logic [6:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic          tx_bit_q, tx_bit_d;
  logic          tx_busy_q, tx_busy_d;
  logic          frame_done_q, frame_done_d;
  logic [15:0]   frame_count_q, frame_count_d;

  logic       full, empty, push, pop, cyc_last;
  logic [6:0] head;

  assign full       = (cnt_q == FULL_CNT);
  assign empty      = (cnt_q == '0);
  assign push       = char_valid && !full;
  assign head       = mem_q[rd_ptr_q];
  assign cyc_last   = (cyc_q == CYC_LAST);
  assign char_ready = !full;

  // A pop while full frees a slot only next cycle; push is already gated by full.
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = char_in;
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_comb begin
    state_d       = state_q;
    cyc_d         = cyc_q;
    bit_d         = bit_q;
    shift_d       = shift_q;
    parity_d      = parity_q;
    frame_count_d = frame_count_q;
    frame_done_d  = 1'b0;
    tx_bit_d      = 1'b1;
    pop           = 1'b0;
    if (state_q != IDLE) cyc_d = cyc_last ? '0 : cyc_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          shift_d  = head;
          parity_d = ^head;
          cyc_d    = '0;
          bit_d    = '0;
          state_d  = START;
        end
      end
      START: begin
        tx_bit_d = 1'b0;
        if (cyc_last) state_d = DATA;
      end
      DATA: begin
        tx_bit_d = shift_q[0];
        if (cyc_last) begin
          shift_d = shift_q >> 1;
          if (bit_q == 3'd6) begin
            bit_d   = '0;
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      PARITY: begin
        tx_bit_d = parity_q;
        if (cyc_last) state_d = STOP;
      end
      STOP: begin
        if (cyc_last) begin
          if (bit_q[1:0] == STOP_LAST) begin
            bit_d         = '0;
            frame_done_d  = 1'b1;
            frame_count_d = frame_count_q + 16'd1;
            // Back-to-back frames: reload straight into START with no idle bit.
            if (!empty) begin
              pop      = 1'b1;
              shift_d  = head;
              parity_d = ^head;
              state_d  = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    tx_busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q         <= '{default: '0};
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cnt_q         <= '0;
      state_q       <= IDLE;
      cyc_q         <= '0;
      bit_q         <= '0;
      shift_q       <= '0;
      parity_q      <= 1'b0;
      tx_bit_q      <= 1'b1;
      tx_busy_q     <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      cnt_q         <= cnt_d;
      state_q       <= state_d;
      cyc_q         <= cyc_d;
      bit_q         <= bit_d;
      shift_q       <= shift_d;
      parity_q      <= parity_d;
      tx_bit_q      <= tx_bit_d;
      tx_busy_q     <= tx_busy_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign tx_bit      = tx_bit_q;
  assign tx_busy     = tx_busy_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_text_uart_tx.sv
// Two configurations (defaults; CPB=1/no parity/2 stops) checked cycle by cycle
// against a queue-based line model: frame start times, bit values, flags, occupancy.
module tb_text_uart_tx;

  typedef struct { logic [6:0] c; int acc; } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input int g, input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL cfg%0d %s at %0t: got %0h, expected %0h", g, tag, $time, obs, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int CPB = (g == 0) ? 4 : 1;
    localparam int PEN = (g == 0) ? 1 : 0;
    localparam int SB  = (g == 0) ? 1 : 2;
    localparam int DEP = 8;
    localparam int L   = (1 + 7 + PEN + SB) * CPB;

    logic        reset = 1'b1;
    logic        char_valid = 1'b0;
    logic [6:0]  char_in = '0;
    logic        char_ready, tx_bit, tx_busy, frame_done;
    logic [15:0] frame_count;
    bit          done = 1'b0;
    bit          nr_seen = 1'b0;

    text_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEP), .PARITY_EN(PEN), .STOP_BITS(SB)) dut (
      .clk(clk), .reset(reset), .char_in(char_in), .char_valid(char_valid),
      .char_ready(char_ready), .tx_bit(tx_bit), .tx_busy(tx_busy),
      .frame_done(frame_done), .frame_count(frame_count)
    );

    // Model state: accepted-but-unsent characters and the frame on the line.
    ent_t q[$];
    ent_t cur;
    int   cyc = 0, pos = 0, last_done = 0, mcount = 0;
    bit   in_frame = 1'b0, rst_pend = 1'b0, armed = 1'b0;

    function automatic logic fbit(input logic [6:0] c, input int p);
      int i;
      i = p / CPB;
      if (i == 0) return 1'b0;
      if (i <= 7) return c[i-1];
      if (PEN != 0 && i == 8) return ^c;
      return 1'b1;
    endfunction

    // Head leaves the line no earlier than 2 edges after acceptance and
    // never before the previous frame has fully ended.
    function automatic int head_start();
      int a, b;
      if (in_frame || q.size() == 0) return -1;
      a = q[0].acc + 2;
      b = last_done + 1;
      return (a > b) ? a : b;
    endfunction

    initial forever begin
      int occ;
      @(negedge clk);
      cyc++;
      if (rst_pend) begin
        q.delete();
        in_frame  = 1'b0;
        last_done = 0;
        mcount    = 0;
        armed     = 1'b1;
      end
      if (armed) begin
        if (in_frame) begin
          chk(g, "tx_bit", 32'(tx_bit), 32'(fbit(cur.c, pos)));
          chk(g, "frame_done", 32'(frame_done), 32'(pos == L - 1));
          if (pos == L - 1) begin
            in_frame  = 1'b0;
            mcount++;
            last_done = cyc;
          end else begin
            pos++;
          end
        end else if (q.size() > 0 && cyc == head_start()) begin
          chk(g, "start_bit", 32'(tx_bit), 32'(0));
          chk(g, "frame_done", 32'(frame_done), 32'(0));
          cur      = q.pop_front();
          in_frame = 1'b1;
          pos      = 1;
        end else begin
          chk(g, "idle_line", 32'(tx_bit), 32'(1));
          chk(g, "frame_done", 32'(frame_done), 32'(0));
        end
        chk(g, "frame_count", 32'(frame_count), 32'(mcount[15:0]));
        // Busy means the line will still be carrying a frame next cycle.
        chk(g, "tx_busy", 32'(tx_busy), 32'(in_frame || head_start() == cyc + 1));
        occ = q.size() - ((head_start() == cyc + 1) ? 1 : 0);
        chk(g, "char_ready", 32'(char_ready), 32'(occ < DEP));
      end
      if (!reset && char_valid && char_ready) q.push_back('{char_in, cyc + 1});
      rst_pend = reset;
    end

    task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic rst(input int n);
      reset = 1'b1;
      tick(n);
      reset = 1'b0;
    endtask

    task automatic send(input logic [6:0] c);
      bit acc;
      acc = 1'b0;
      char_in = c;
      char_valid = 1'b1;
      for (int i = 0; i < 2000 && !acc; i++) begin
        @(negedge clk);
        acc = char_ready;
        if (!char_ready) nr_seen = 1'b1;
        @(posedge clk); #1;
      end
      if (!acc) chk(g, "send_timeout", 32'(0), 32'(1));
      char_valid = 1'b0;
      char_in = 7'bx;
    endtask

    task automatic drain();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 20000 && !ok; i++) begin
        @(negedge clk);
        ok = (q.size() == 0) && !in_frame && !tx_busy;
      end
      if (!ok) chk(g, "drain_timeout", 32'(0), 32'(1));
      @(posedge clk); #1;
    endtask

    initial begin
      tick(3);
      reset = 1'b0;
      tick(100);
      chk(g, "idle_count", 32'(frame_count), 32'(0));
      chk(g, "idle_tx", 32'(tx_bit), 32'(1));

      rst(1);
      send(7'h05);
      drain();
      chk(g, "count_05", 32'(frame_count), 32'(1));

      rst(1);
      send(7'h41);
      send(7'h43);
      drain();
      chk(g, "count_pair", 32'(frame_count), 32'(2));

      rst(1);
      nr_seen = 1'b0;
      for (int i = 0; i < 12; i++) send(7'(7'h30 + i));
      drain();
      chk(g, "ready_dropped", 32'(nr_seen), 32'(1));
      chk(g, "count_burst", 32'(frame_count), 32'(12));

      rst(1);
      for (int i = 0; i < 4; i++) send(7'(7'h61 + i));
      tick(4 * CPB);
      rst(1);
      chk(g, "abort_tx", 32'(tx_bit), 32'(1));
      chk(g, "abort_ready", 32'(char_ready), 32'(1));
      chk(g, "abort_busy", 32'(tx_busy), 32'(0));
      chk(g, "abort_count", 32'(frame_count), 32'(0));
      tick(60);
      chk(g, "abort_after", 32'(frame_count), 32'(0));

      rst(1);
      send(7'h7F);
      drain();
      chk(g, "count_7f", 32'(frame_count), 32'(1));

      rst(1);
      for (int i = 0; i < 300; i++) begin
        if ($urandom_range(0, 2) == 0) send(7'($urandom));
        else if ($urandom_range(0, 249) == 0) rst(1);
        else tick(1);
      end
      drain();
      done = 1'b1;
    end
  end

  initial begin
    bit fin;
    fin = 1'b0;
    for (int i = 0; i < 60000 && !fin; i++) begin
      @(posedge clk);
      fin = cfg[0].done && cfg[1].done;
    end
    if (!fin) chk(9, "global_timeout", 32'(0), 32'(1));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/text_uart_tx.md
Name: text_uart_tx

Overview:
- Downstream stage of the text processing top level; consumes the 7-bit ASCII characters that block produces.
- Buffers characters in a small FIFO and serialises each as an asynchronous frame: start bit, 7 data bits LSB first, optional even parity, stop bit(s).
- Output line `tx_bit` drives the channel/modulator model of the link.

Parameters:
- CLKS_PER_BIT, 4, clock cycles each serial bit is held (≥1).
- FIFO_DEPTH, 8, character buffer depth (power of two, ≥2).
- PARITY_EN, 1, 1 = insert even-parity bit after data, 0 = no parity bit.
- STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- char_in  input  7  ASCII character from upstream text stage
- char_valid  input  1  char_in holds a valid character this cycle
- char_ready  output  1  FIFO can accept; transfer occurs when char_valid && char_ready at a rising edge
- tx_bit  output  1  serial line, idle high
- tx_busy  output  1  high whenever state ≠ IDLE
- frame_done  output  1  one-cycle pulse at end of each frame's final stop-bit period
- frame_count  output  16  frames completed since reset, wraps 0xFFFF→0x0000

Behaviour:
- Interface: one clock, `clk`. `reset` is synchronous and active-high, sampled on rising edge of `clk`.
- Reset values:
  - tx_bit=1, tx_busy=0, frame_done=0, frame_count=0, char_ready=1.
  - FIFO empty (pointers 0), state=IDLE, bit/cycle counters 0.
- Reset mid-frame: the next edge aborts the frame, tx_bit=1, FIFO flushed, partial character discarded, frame_count not incremented.
- FIFO:
  - char_ready = !full, combinational from registered occupancy only.
  - When full, no write occurs even if a pop happens the same cycle.
  - Simultaneous push and pop when not full: occupancy unchanged, both take effect.
  - Occupancy counter is log2(FIFO_DEPTH)+1 bits; pointers wrap modulo FIFO_DEPTH.
- State machine states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx_bit=1. If FIFO non-empty, pop the head into a 7-bit shift register, compute parity = XOR of the 7 bits, go to START.
  - START: tx_bit=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: tx_bit = shift register bit 0, held CLKS_PER_BIT cycles per bit, then shift right. After 7 bits go to PARITY if PARITY_EN else STOP.
  - PARITY: tx_bit = parity, CLKS_PER_BIT cycles, then STOP.
  - STOP: tx_bit=1 for STOP_BITS*CLKS_PER_BIT cycles. On the last cycle: pulse frame_done, increment frame_count. If FIFO non-empty, pop and go directly to START (no idle gap), else IDLE.
- Latency: a character accepted at edge N into an empty FIFO with the block idle is popped at edge N+1; tx_bit goes low at edge N+2.
- Frame length: (1+7+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles; 40 with defaults.
- tx_bit, tx_busy and frame_done are registered outputs (no combinational path from inputs).
- char_in is ignored when char_valid=0; X on char_in with valid low must not propagate.

Test Plan:
- Reset then idle, no valid → tx_bit=1, char_ready=1, tx_busy=0, frame_count=0 for 100 cycles.
- Push 7'h05 once → tx_bit low 2 cycles after accept. Sequence in 4-cycle bits: 0, 1,0,1,0,0,0,0, parity 0, stop 1. frame_done pulses once; frame_count=1 after 40 cycles of frame.
- Push 7'h41 then 7'h43 back-to-back → two contiguous 40-cycle frames with no idle gap. Parity bits 0 and 1 respectively; frame_count=2.
- Hold char_valid high for 12 distinct characters → char_ready drops once 8 are stored (one already popped into the shift register). All 12 are eventually sent, in order, with no loss or duplicates; frame_count=12.
- Assert reset for one cycle midway through the DATA bits of a frame with 3 chars queued → tx_bit=1 next cycle, FIFO empty, frame_count=0. No frame_done for the aborted frame.
- PARITY_EN=0, STOP_BITS=2, CLKS_PER_BIT=1, char 7'h7F → 10-cycle frame: 0, seven 1s, 1, 1.
